// File: rtl/muldiv_ctrl_if.sv
// Request, unit and result signals between the pipeline/mult/div units and muldiv_ctrl.
// slave = the sequencer's view; master = the pipeline and units driving it.
interface muldiv_ctrl_if #(
    parameter int N_BITS = 32
);
    logic              op_start;
    logic              op_sel;
    logic [N_BITS-1:0] srcA;
    logic [N_BITS-1:0] srcB;
    logic              hi_we;
    logic              lo_we;
    logic [N_BITS-1:0] wr_data;
    logic [N_BITS-1:0] unitA;
    logic [N_BITS-1:0] unitB;
    logic              multCtrl;
    logic              divCtrl;
    logic [N_BITS-1:0] mult_hi;
    logic [N_BITS-1:0] mult_lo;
    logic [N_BITS-1:0] div_hi;
    logic [N_BITS-1:0] div_lo;
    logic [N_BITS-1:0] hi;
    logic [N_BITS-1:0] lo;
    logic              busy;
    logic              stall;
    logic              done;
    logic              div_zero;

    modport slave (
        input  op_start, op_sel, srcA, srcB, hi_we, lo_we, wr_data,
        input  mult_hi, mult_lo, div_hi, div_lo,
        output unitA, unitB, multCtrl, divCtrl, hi, lo, busy, stall, done, div_zero
    );

    modport master (
        output op_start, op_sel, srcA, srcB, hi_we, lo_we, wr_data,
        output mult_hi, mult_lo, div_hi, div_lo,
        input  unitA, unitB, multCtrl, divCtrl, hi, lo, busy, stall, done, div_zero
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Sequences MULT/DIV requests to external units and owns HI/LO; optional MULDIV_DIVZERO_EN short-circuits DIV by zero.
// Latency: done pulses LAT+1 edges after op acceptance (2 edges for a short-circuited divide by zero).
// Backpressure: stall while busy; requests/writes during busy are ignored and must be held by the requester.
module muldiv_ctrl #(
    parameter int N_BITS      = 32,
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CAPT = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              sel_q;
    logic              dz_q;
    logic              div_zero_q;
    logic [N_BITS-1:0] unit_a_q;
    logic [N_BITS-1:0] unit_b_q;
    logic [N_BITS-1:0] hi_q;
    logic [N_BITS-1:0] lo_q;
    logic              mult_go;
    logic              div_go;
    logic              busy_q;
    logic              done_q;
    logic              div_by_zero;

`ifdef MULDIV_DIVZERO_EN
    assign div_by_zero = bus.op_sel && (bus.srcB == '0);
`else
    assign div_by_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            sel_q      <= 1'b0;
            dz_q       <= 1'b0;
            div_zero_q <= 1'b0;
            unit_a_q   <= '0;
            unit_b_q   <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            mult_go    <= 1'b0;
            div_go     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            mult_go <= 1'b0;
            div_go  <= 1'b0;
            done_q  <= 1'b0;
            unique case (state)
                // CAPT is the done cycle; it accepts work exactly like IDLE so ops can run back to back.
                IDLE, CAPT: begin
                    if (bus.op_start) begin
                        unit_a_q <= bus.srcA;
                        unit_b_q <= bus.srcB;
                        sel_q    <= bus.op_sel;
                        dz_q     <= div_by_zero;
                        busy_q   <= 1'b1;
                        state    <= RUN;
                        if (div_by_zero) begin
                            cnt <= CNT_W'(1);
                        end else begin
                            mult_go <= !bus.op_sel;
                            div_go  <= bus.op_sel;
                            cnt     <= bus.op_sel ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        end
                    end else begin
                        state <= IDLE;
                        if (bus.hi_we) hi_q <= bus.wr_data;
                        if (bus.lo_we) lo_q <= bus.wr_data;
                    end
                end
                RUN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (dz_q) begin
                            div_zero_q <= 1'b1;
                        end else begin
                            hi_q <= sel_q ? bus.div_hi : bus.mult_hi;
                            lo_q <= sel_q ? bus.div_lo : bus.mult_lo;
                        end
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= CAPT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.unitA    = unit_a_q;
    assign bus.unitB    = unit_b_q;
    assign bus.multCtrl = mult_go;
    assign bus.divCtrl  = div_go;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = busy_q;
    assign bus.stall    = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized scoreboard bench for muldiv_ctrl with behavioural mult/div unit models.
module tb_muldiv_ctrl;
    localparam int N  = 32;
    localparam int MC = 32;
    localparam int DC = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    muldiv_ctrl_if #(.N_BITS(N)) bus();

    muldiv_ctrl #(
        .N_BITS(N), .MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External units: results appear only after their latency; garbage before that.
    logic [63:0] garb = 64'h0;
    logic [63:0] m_res = 64'h0, d_res = 64'h0;
    int          m_rem = 0, d_rem = 0;
    always @(posedge clk) begin
        garb <= {$urandom, $urandom};
        if (bus.multCtrl) begin
            m_res <= {32'h0, bus.unitA} * {32'h0, bus.unitB};
            m_rem <= MC - 1;
        end else if (m_rem != 0) m_rem <= m_rem - 1;
        if (bus.divCtrl) begin
            d_res <= (bus.unitB == 0) ? {bus.unitA, 32'hFFFF_FFFF}
                                      : {bus.unitA % bus.unitB, bus.unitA / bus.unitB};
            d_rem <= DC - 1;
        end else if (d_rem != 0) d_rem <= d_rem - 1;
    end
    assign bus.mult_hi = (m_rem == 0) ? m_res[63:32] : garb[63:32];
    assign bus.mult_lo = (m_rem == 0) ? m_res[31:0]  : garb[31:0];
    assign bus.div_hi  = (d_rem == 0) ? d_res[63:32] : garb[31:0];
    assign bus.div_lo  = (d_rem == 0) ? d_res[31:0]  : garb[63:32];

    typedef struct { logic [31:0] hi; logic [31:0] lo; int cyc; logic dz; } exp_t;
    typedef struct { logic sel; int cyc; } st_t;
    exp_t done_q[$];
    st_t  start_q[$];
    logic [31:0] ref_hi = 0, ref_lo = 0;
    logic        ref_dz = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a done or a unit start.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.done) begin
                if (done_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = done_q.pop_front();
                    check("done_cycle", 64'(cyc), 64'(e.cyc));
                    check("hi", 64'(bus.hi), 64'(e.hi));
                    check("lo", 64'(bus.lo), 64'(e.lo));
                    check("busy_at_done", 64'(bus.busy), 64'd0);
                    check("div_zero", 64'(bus.div_zero), 64'(e.dz));
                end
            end
            if (bus.multCtrl || bus.divCtrl) begin
                if (start_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_start: got mult=%0b div=%0b expected none (cycle %0d)",
                             bus.multCtrl, bus.divCtrl, cyc);
                end else begin
                    st_t s;
                    s = start_q.pop_front();
                    check("start_cycle", 64'(cyc), 64'(s.cyc));
                    check("start_div", 64'(bus.divCtrl), 64'(s.sel));
                    check("start_mult", 64'(bus.multCtrl), 64'(!s.sel));
                end
            end
        end
    end

    // Called at a negedge with the DUT idle or in its done cycle; returns #1 after acceptance.
    task automatic do_op(input logic sel, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        st_t         s;
        logic [63:0] p;
        int          lat;
        logic        dz;
        bus.op_start = 1'b1;
        bus.op_sel   = sel;
        bus.srcA     = a;
        bus.srcB     = b;
        @(posedge clk);
        #1;
        bus.op_start = 1'b0;
        bus.srcA     = $urandom;
        bus.srcB     = $urandom;
        dz = 1'b0;
`ifdef MULDIV_DIVZERO_EN
        dz = sel && (b == 0);
`endif
        if (dz) begin
            ref_dz = 1'b1;
            lat    = 1;
        end else if (!sel) begin
            p      = {32'h0, a} * {32'h0, b};
            ref_hi = p[63:32];
            ref_lo = p[31:0];
            lat    = MC;
        end else begin
            ref_hi = (b == 0) ? a : a % b;
            ref_lo = (b == 0) ? 32'hFFFF_FFFF : a / b;
            lat    = DC;
        end
        check("unitA_latched", 64'(bus.unitA), 64'(a));
        check("unitB_latched", 64'(bus.unitB), 64'(b));
        e.hi = ref_hi; e.lo = ref_lo; e.cyc = cyc + lat + 1; e.dz = ref_dz;
        done_q.push_back(e);
        if (!dz) begin
            s.sel = sel; s.cyc = cyc;
            start_q.push_back(s);
        end
    endtask

    task automatic wait_done();
        bit got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (bus.done) got = 1'b1;
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL done_timeout: got no done expected done within 100 cycles");
        end
    endtask

    task automatic do_write(input logic h, input logic l, input logic [31:0] d);
        bus.hi_we   = h;
        bus.lo_we   = l;
        bus.wr_data = d;
        @(posedge clk);
        #1;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        if (h) ref_hi = d;
        if (l) ref_lo = d;
        @(negedge clk);
        check("write_hi", 64'(bus.hi), 64'(ref_hi));
        check("write_lo", 64'(bus.lo), 64'(ref_lo));
        check("write_no_done", 64'(bus.done), 64'd0);
    endtask

    initial begin
        bus.op_start = 1'b0; bus.op_sel = 1'b0; bus.srcA = '0; bus.srcB = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wr_data = '0;
        #1;
        check("reset_state", {bus.hi, bus.lo}, 64'd0);
        check("reset_units", {bus.unitA, bus.unitB}, 64'd0);
        check("reset_ctrl", {59'd0, bus.busy, bus.stall, bus.done, bus.multCtrl, bus.divCtrl}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        do_op(1'b0, 32'd1878982656, 32'd8);
        wait_done();
        do_op(1'b1, 32'd100, 32'd7);
        wait_done();
        @(negedge clk);
        do_write(1'b1, 1'b1, 32'hDEAD_BEEF);
        do_write(1'b0, 1'b1, 32'h1234_5678);

        // Requests and writes while busy are ignored.
        do_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0003);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stall_busy", 64'(bus.stall), 64'd1);
            bus.op_start = 1'b1; bus.op_sel = 1'b1; bus.hi_we = 1'b1; bus.wr_data = 32'hBAD0_BAD0;
        end
        @(negedge clk);
        bus.op_start = 1'b0; bus.hi_we = 1'b0;
        wait_done();
        @(negedge clk);
        check("hi_after_stall", 64'(bus.hi), 64'(ref_hi));
        check("stall_idle", 64'(bus.stall), 64'd0);

`ifdef MULDIV_DIVZERO_EN
        do_op(1'b1, 32'd5, 32'd0);
        wait_done();
        @(negedge clk);
`endif

        // Random ops, half of them issued in the done cycle of the previous one.
        for (int i = 0; i < 20; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 16)) : $urandom;
            if (b == 0) b = 1;
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 255));
            do_op(1'($urandom_range(0, 1)), a, b);
            wait_done();
            if ($urandom_range(0, 2) == 0)
                do_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            else if ($urandom_range(0, 1) == 0)
                @(negedge clk);
        end

        // Asynchronous reset mid-op.
        @(negedge clk);
        do_op(1'b0, 32'h0BAD_F00D, 32'h77);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("areset_hilo", {bus.hi, bus.lo}, 64'd0);
        check("areset_units", {bus.unitA, bus.unitB}, 64'd0);
        check("areset_ctrl",
              {58'd0, bus.busy, bus.stall, bus.done, bus.multCtrl, bus.divCtrl, bus.div_zero}, 64'd0);
        done_q.delete();
        start_q.delete();
        ref_hi = 0; ref_lo = 0; ref_dz = 0;
        @(negedge clk);
        reset = 1'b1;
        repeat (45) @(negedge clk);
        check("post_reset_hilo", {bus.hi, bus.lo}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
